addr_gen: RTL and testbench

- Parametrised successor to the fixed 21-bit address shift register and counter pair that feeds sram_addr.
- The AVR loads a start address serially and commits it atomically. It then steps the address with falling edges on avr_counter_n.
- Step size is programmable. Four step modes: linear, masked wrap (ring buffers), decrement, hold.
- Sits between AVR control pins and the SRAM address bus. Drives sram_addr directly.

---
 rtl/addr_gen_if.sv | 26 ++
 rtl/addr_gen.sv | 125 ++++++++++++
 tb/tb_addr_gen.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/addr_gen_if.sv
// AVR-side control and SRAM address bus of addr_gen, with master (AVR/bench)
// and slave (addr_gen) views.
interface addr_gen_if #(
   parameter int ADDR_W = 21,
   parameter int STEP_W = 4
);
   logic              avr_si;
   logic              avr_sreg_en_n;
   logic              avr_counter_n;
   logic [STEP_W-1:0] step;
   logic [1:0]        mode;
   logic [ADDR_W-1:0] wrap_mask;
   logic [ADDR_W-1:0] sram_addr;
   logic              addr_wrap;
   logic              avr_so;

   modport master (
      output avr_si, avr_sreg_en_n, avr_counter_n, step, mode, wrap_mask,
      input  sram_addr, addr_wrap, avr_so
   );

   modport slave (
      input  avr_si, avr_sreg_en_n, avr_counter_n, step, mode, wrap_mask,
      output sram_addr, addr_wrap, avr_so
   );
endinterface

// File: rtl/addr_gen.sv
// Serially loaded SRAM address register with programmable up/ring/down stepping.
// Define ADDR_GEN_READBACK_EN to shift the current address out on avr_so while loading.
module addr_gen #(
   parameter int ADDR_W          = 21,
   parameter int STEP_W          = 4,
   parameter bit SHIFT_MSB_FIRST = 1'b1
) (
   input logic       avr_clk,
   input logic       avr_reset,
   addr_gen_if.slave bus
);
   logic [ADDR_W-1:0] shadow_r;
   logic [ADDR_W-1:0] shadow_nxt_s;
   logic [ADDR_W-1:0] shadow_shift_s;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W-1:0] addr_nxt_s;
   logic [ADDR_W-1:0] step_ext_s;
   logic [ADDR_W:0]   sum_s;
   logic [ADDR_W:0]   diff_s;
   logic [ADDR_W:0]   field_sum_s;
   logic              wrap_r;
   logic              wrap_nxt_s;
   logic              en_d_r;
   logic              cnt_d_r;
   logic              commit_s;
   logic              step_req_s;

   // Edge detection on the AVR pins and the widened step arithmetic.
   always_comb begin
      commit_s    = ~en_d_r & bus.avr_sreg_en_n;
      step_req_s  = cnt_d_r & ~bus.avr_counter_n;
      step_ext_s  = ADDR_W'(bus.step);
      sum_s       = {1'b0, addr_r} + {1'b0, step_ext_s};
      diff_s      = {1'b0, addr_r} - {1'b0, step_ext_s};
      field_sum_s = {1'b0, addr_r & bus.wrap_mask} + {1'b0, step_ext_s};
   end

   // Shadow register: serial load, otherwise idle or tracking the address.
   always_comb begin
      shadow_shift_s = shadow_r;
      if (SHIFT_MSB_FIRST) begin
         shadow_shift_s = {shadow_r[ADDR_W-2:0], bus.avr_si};
      end else begin
         shadow_shift_s = {bus.avr_si, shadow_r[ADDR_W-1:1]};
      end

      shadow_nxt_s = shadow_r;
      if (!bus.avr_sreg_en_n) begin
         shadow_nxt_s = shadow_shift_s;
`ifdef ADDR_GEN_READBACK_EN
      end else if (!commit_s) begin
         shadow_nxt_s = addr_r;
      end else begin
         shadow_nxt_s = shadow_r;
      end
`else
      end else begin
         shadow_nxt_s = shadow_r;
      end
`endif
   end

   // Address update: commit has priority over a step in the same cycle.
   always_comb begin
      addr_nxt_s = addr_r;
      wrap_nxt_s = 1'b0;
      if (commit_s) begin
         addr_nxt_s = shadow_r;
      end else if (step_req_s) begin
         case (bus.mode)
            2'b00: begin
               addr_nxt_s = sum_s[ADDR_W-1:0];
               wrap_nxt_s = sum_s[ADDR_W];
            end
            2'b01: begin
               // Ring field is assumed contiguous from bit 0, so the carry
               // out of the field shows up as a sum above the mask.
               addr_nxt_s = (addr_r & ~bus.wrap_mask) | (sum_s[ADDR_W-1:0] & bus.wrap_mask);
               wrap_nxt_s = (bus.wrap_mask != {ADDR_W{1'b0}}) &&
                            (field_sum_s > {1'b0, bus.wrap_mask});
            end
            2'b10: begin
               addr_nxt_s = diff_s[ADDR_W-1:0];
               wrap_nxt_s = diff_s[ADDR_W];
            end
            2'b11: begin
               addr_nxt_s = addr_r;
               wrap_nxt_s = 1'b0;
            end
            default: begin
               addr_nxt_s = addr_r;
               wrap_nxt_s = 1'b0;
            end
         endcase
      end else begin
         addr_nxt_s = addr_r;
         wrap_nxt_s = 1'b0;
      end
   end

   // State registers with synchronous reset; edge registers idle high.
   always_ff @(posedge avr_clk) begin
      if (avr_reset) begin
         shadow_r <= {ADDR_W{1'b0}};
         addr_r   <= {ADDR_W{1'b0}};
         wrap_r   <= 1'b0;
         en_d_r   <= 1'b1;
         cnt_d_r  <= 1'b1;
      end else begin
         shadow_r <= shadow_nxt_s;
         addr_r   <= addr_nxt_s;
         wrap_r   <= wrap_nxt_s;
         en_d_r   <= bus.avr_sreg_en_n;
         cnt_d_r  <= bus.avr_counter_n;
      end
   end

   assign bus.sram_addr = addr_r;
   assign bus.addr_wrap = wrap_r;
`ifdef ADDR_GEN_READBACK_EN
   assign bus.avr_so = SHIFT_MSB_FIRST ? shadow_r[ADDR_W-1] : shadow_r[0];
`else
   assign bus.avr_so = 1'b0;
`endif
endmodule

// File: tb/tb_addr_gen.sv
// Scoreboard bench for addr_gen (ADDR_W=16, MSB first): directed scenarios plus
// random stimulus, every cycle checked against an arithmetic reference model.
module tb_addr_gen;
   localparam int AW = 16;
   localparam int unsigned AMOD = 32'h0001_0000;
`ifdef ADDR_GEN_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   typedef struct {
      logic [AW-1:0] addr;
      logic          wrap;
      logic          so;
   } exp_t;

   logic avr_clk = 1'b0;
   logic avr_reset = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t exp_q[$];

   int unsigned m_addr = 0, m_shadow = 0;
   bit m_wrap = 1'b0, m_en_d = 1'b1, m_cnt_d = 1'b1;

   addr_gen_if #(.ADDR_W(AW), .STEP_W(4)) bus ();

   addr_gen #(.ADDR_W(AW), .STEP_W(4), .SHIFT_MSB_FIRST(1'b1)) dut (
      .avr_clk  (avr_clk),
      .avr_reset(avr_reset),
      .bus      (bus)
   );

   always #5 avr_clk = ~avr_clk;

   // One clock: sample the applied inputs, advance the reference model, queue the expectation.
   task automatic tick();
      int unsigned st, mk, fld, nf, old_shadow;
      bit commit, sreq;
      exp_t e;
      @(posedge avr_clk);
      st = 32'(bus.step);
      mk = 32'(bus.wrap_mask);
      if (avr_reset) begin
         m_addr = 0; m_shadow = 0; m_wrap = 1'b0; m_en_d = 1'b1; m_cnt_d = 1'b1;
      end else begin
         commit = !m_en_d && bus.avr_sreg_en_n;
         sreq   = m_cnt_d && !bus.avr_counter_n;
         old_shadow = m_shadow;
         if (!bus.avr_sreg_en_n) m_shadow = (m_shadow * 2 + 32'(bus.avr_si)) % AMOD;
         else if (RB && !commit) m_shadow = m_addr;
         m_wrap = 1'b0;
         if (commit) begin
            m_addr = old_shadow;
         end else if (sreq) begin
            case (bus.mode)
               2'd0: begin m_wrap = (m_addr + st) >= AMOD; m_addr = (m_addr + st) % AMOD; end
               2'd1: if (mk != 0) begin
                  fld = m_addr & mk;
                  nf  = fld + st;
                  m_wrap = nf > mk;
                  m_addr = (m_addr - fld) + (nf % (mk + 1));
               end
               2'd2: begin m_wrap = st > m_addr; m_addr = (m_addr + AMOD - st) % AMOD; end
               default: ;
            endcase
         end
         m_en_d  = bus.avr_sreg_en_n;
         m_cnt_d = bus.avr_counter_n;
      end
      e.addr = m_addr[AW-1:0];
      e.wrap = m_wrap;
      e.so   = RB ? m_shadow[AW-1] : 1'b0;
      exp_q.push_back(e);
      #1;
   endtask

   // Monitor: compare DUT outputs to the oldest expectation on the falling edge.
   always @(negedge avr_clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (bus.sram_addr !== e.addr || bus.addr_wrap !== e.wrap || bus.avr_so !== e.so) begin
            miscompares++;
            $display("FAIL scoreboard t=%0t: got addr=%h wrap=%b so=%b, want addr=%h wrap=%b so=%b",
                     $time, bus.sram_addr, bus.addr_wrap, bus.avr_so, e.addr, e.wrap, e.so);
         end
      end
   end

   task automatic check(string name, int unsigned act, int unsigned exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic shift_in(int unsigned val, int n);
      for (int i = n - 1; i >= 0; i--) begin
         bus.avr_si = val[i];
         bus.avr_sreg_en_n = 1'b0;
         tick();
      end
      bus.avr_sreg_en_n = 1'b1;
      tick();
   endtask

   task automatic step_once(bit [1:0] md, int unsigned st, int unsigned mk);
      bus.mode = md; bus.step = 4'(st); bus.wrap_mask = 16'(mk);
      bus.avr_counter_n = 1'b0;
      tick();
   endtask

   task automatic release_cnt();
      bus.avr_counter_n = 1'b1;
      tick();
   endtask

   initial begin
      logic [AW-1:0] so_seq;
      bus.avr_si = 1'b0; bus.avr_sreg_en_n = 1'b1; bus.avr_counter_n = 1'b1;
      bus.step = 4'd0; bus.mode = 2'b00; bus.wrap_mask = 16'h0000;
      avr_reset = 1'b1;
      tick(); tick();
      check("reset_addr", 32'(bus.sram_addr), 32'h0);
      check("reset_wrap", 32'(bus.addr_wrap), 32'h0);
      avr_reset = 1'b0;
      tick();

      // Serial load and commit
      shift_in(32'h4ccf, 16);
      check("load_4ccf", 32'(bus.sram_addr), 32'h4ccf);

      // One step per falling edge, pin held low
      step_once(2'b00, 1, 0);
      check("lin_step", 32'(bus.sram_addr), 32'h4cd0);
      for (int i = 0; i < 4; i++) tick();
      check("lin_hold_low", 32'(bus.sram_addr), 32'h4cd0);
      check("lin_no_wrap", 32'(bus.addr_wrap), 32'h0);
      release_cnt();

      // Ring wrap
      shift_in(32'h4ccf, 16);
      step_once(2'b01, 1, 32'h000f);
      check("ring_wrap_addr", 32'(bus.sram_addr), 32'h4cc0);
      check("ring_wrap_pulse", 32'(bus.addr_wrap), 32'h1);
      release_cnt();
      check("ring_pulse_end", 32'(bus.addr_wrap), 32'h0);
      step_once(2'b01, 3, 32'h000f);
      check("ring_step3", 32'(bus.sram_addr), 32'h4cc3);
      check("ring_step3_nowrap", 32'(bus.addr_wrap), 32'h0);
      release_cnt();

      // Decrement borrow and hold mode
      shift_in(32'h0000, 16);
      step_once(2'b10, 2, 0);
      check("dec_borrow_addr", 32'(bus.sram_addr), 32'hfffe);
      check("dec_borrow_pulse", 32'(bus.addr_wrap), 32'h1);
      release_cnt();
      step_once(2'b11, 5, 0);
      check("hold_addr", 32'(bus.sram_addr), 32'hfffe);
      check("hold_nowrap", 32'(bus.addr_wrap), 32'h0);
      release_cnt();

      // Commit beats a same-cycle step
      for (int i = 15; i >= 0; i--) begin
         bus.avr_si = 1'((32'h1234 >> i) & 32'h1);
         bus.avr_sreg_en_n = 1'b0;
         tick();
      end
      bus.mode = 2'b00; bus.step = 4'd7;
      bus.avr_sreg_en_n = 1'b1; bus.avr_counter_n = 1'b0;
      tick();
      check("commit_wins", 32'(bus.sram_addr), 32'h1234);
      release_cnt();

      // Reset mid-shift
      bus.avr_sreg_en_n = 1'b0; bus.avr_si = 1'b1;
      tick(); tick(); tick();
      avr_reset = 1'b1;
      tick();
      check("rst_mid_addr", 32'(bus.sram_addr), 32'h0);
      check("rst_mid_wrap", 32'(bus.addr_wrap), 32'h0);
      avr_reset = 1'b0; bus.avr_sreg_en_n = 1'b1;
      tick();
      check("rst_no_commit", 32'(bus.sram_addr), 32'h0);

      // Readback while shifting in zeros
      shift_in(32'h4cd0, 16);
      tick();
      for (int i = AW - 1; i >= 0; i--) begin
         so_seq[i] = bus.avr_so;
         bus.avr_si = 1'b0; bus.avr_sreg_en_n = 1'b0;
         tick();
      end
      bus.avr_sreg_en_n = 1'b1;
      tick();
      check("zero_commit", 32'(bus.sram_addr), 32'h0);
      if (RB) check("readback_seq", 32'(so_seq), 32'h4cd0);
      else    check("so_tied_low", 32'(so_seq), 32'h0);

      // Random stimulus
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 7) == 0) bus.avr_sreg_en_n = ~bus.avr_sreg_en_n;
         if ($urandom_range(0, 2) == 0) bus.avr_counter_n = ~bus.avr_counter_n;
         bus.avr_si    = 1'($urandom_range(0, 1));
         bus.step      = 4'($urandom_range(0, 15));
         bus.mode      = 2'($urandom_range(0, 3));
         bus.wrap_mask = 16'((32'h1 << $urandom_range(0, 16)) - 32'h1);
         avr_reset     = ($urandom_range(0, 299) == 0);
         tick();
      end
      avr_reset = 1'b0;
      tick();

      @(negedge avr_clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
